// File: rtl/chan2uart.sv
// UART transmitter: takes bytes from a valid/ready channel and sends each as one
// asynchronous serial frame (start, data LSB first, optional parity, stop bits).
module chan2uart #(
  parameter int unsigned CLOCK_DIV = 104,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [DATA_BITS-1:0] idata,
  input  logic                 ivalid,
  output logic                 iready,
  output logic                 txd,
  output logic                 busy
);

  localparam int unsigned      BaudW      = $clog2(CLOCK_DIV);
  localparam logic [BaudW-1:0] BaudLast   = BaudW'(CLOCK_DIV - 1);
  localparam logic [BaudW-1:0] BaudPenult = BaudW'(CLOCK_DIV - 2);
  localparam logic [3:0]       DataLast   = 4'(DATA_BITS - 1);
  localparam logic [3:0]       StopLast   = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 txd_q, txd_d;
  logic                 iready_q, iready_d;
  logic                 busy_q, busy_d;

  logic accept, bit_end, last_data, last_stop;

  assign accept    = ivalid & iready_q;
  assign bit_end   = (baud_q == BaudLast);
  assign last_data = (bitcnt_q == DataLast);
  assign last_stop = (bitcnt_q == StopLast);

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      iready_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
      iready_q <= iready_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StStart;
      StStart:  if (bit_end) state_d = StData;
      StData: begin
        if (bit_end && last_data) state_d = (PARITY != 0) ? StParity : StStop;
      end
      StParity: if (bit_end) state_d = StStop;
      StStop: begin
        if (bit_end && last_stop) state_d = accept ? StStart : StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  // Counters, shift register and parity.
  always_comb begin
    baud_d   = bit_end ? '0 : baud_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    // Idle holds the baud counter at zero so the start bit spans a full bit time.
    if (state_q == StIdle) baud_d = '0;

    if (bit_end) begin
      case (state_q)
        StData:  bitcnt_d = last_data ? '0 : bitcnt_q + 4'd1;
        StStop:  bitcnt_d = last_stop ? '0 : bitcnt_q + 4'd1;
        default: bitcnt_d = '0;
      endcase
    end

    if (accept) begin
      shift_d  = idata;
      parity_d = (PARITY == 1) ? ~(^idata) : ^idata;
    end else if (state_q == StData && bit_end) begin
      shift_d = shift_q >> 1;
    end
  end

  // Registered outputs, derived from the upcoming state.
  always_comb begin
    busy_d   = (state_d != StIdle);
    // Ready one cycle early so a waiting word starts right at the frame boundary.
    iready_d = (state_d == StIdle) ||
               (state_q == StStop && last_stop && baud_q == BaudPenult);
    txd_d    = 1'b1;
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
      StParity: txd_d = parity_q;
      default:  txd_d = 1'b1;
    endcase
  end

  assign txd    = txd_q;
  assign iready = iready_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_chan2uart.sv
// Directed bench for chan2uart: frame vectors over four parameter sets plus
// back-to-back, stall and mid-frame reset sequences.
module tb_chan2uart;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] idata [4];
  logic [3:0] ivalid, iready, txd, busy;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  chan2uart #(.CLOCK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_none (
    .clock(clock), .resetn(resetn), .idata(idata[0]), .ivalid(ivalid[0]),
    .iready(iready[0]), .txd(txd[0]), .busy(busy[0]));

  chan2uart #(.CLOCK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clock(clock), .resetn(resetn), .idata(idata[1]), .ivalid(ivalid[1]),
    .iready(iready[1]), .txd(txd[1]), .busy(busy[1]));

  chan2uart #(.CLOCK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clock(clock), .resetn(resetn), .idata(idata[2]), .ivalid(ivalid[2]),
    .iready(iready[2]), .txd(txd[2]), .busy(busy[2]));

  chan2uart #(.CLOCK_DIV(5), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .clock(clock), .resetn(resetn), .idata(idata[3]), .ivalid(ivalid[3]),
    .iready(iready[3]), .txd(txd[3]), .busy(busy[3]));

  typedef struct {
    int          idx;
    int          div;
    int          nb;
    logic [15:0] bits;  // bit i is the i-th serial bit on the line
    logic [7:0]  data;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Caller sets idata/ivalid at a negedge; returns at the negedge of the last frame cycle.
  task automatic frame(input int idx, input int div, input int nb, input logic [15:0] bits,
                       input bit hold, input logic [7:0] nxt, input bit noise);
    int f = div * nb;
    check($sformatf("ready_before u%0d", idx), 16'(iready[idx]), 16'd1);
    @(posedge clock);
    for (int k = 0; k < f; k++) begin
      @(negedge clock);
      check($sformatf("txd u%0d k%0d", idx, k), 16'(txd[idx]), 16'(bits[k / div]));
      check($sformatf("iready u%0d k%0d", idx, k), 16'(iready[idx]), 16'(k == f - 1));
      check($sformatf("busy u%0d k%0d", idx, k), 16'(busy[idx]), 16'd1);
      if (k == f - 1) begin
        ivalid[idx] = hold;
        if (hold) idata[idx] = nxt;
      end else if (noise) begin
        ivalid[idx] = 1'($urandom);
        idata[idx]  = 8'($urandom);
      end else if (!hold) begin
        ivalid[idx] = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input int idx);
    @(negedge clock);
    check($sformatf("idle txd u%0d", idx), 16'(txd[idx]), 16'd1);
    check($sformatf("idle iready u%0d", idx), 16'(iready[idx]), 16'd1);
    check($sformatf("idle busy u%0d", idx), 16'(busy[idx]), 16'd0);
  endtask

  initial begin
    vecs[0] = '{idx: 0, div: 4, nb: 10, bits: 16'h02AA, data: 8'h55};
    vecs[1] = '{idx: 1, div: 4, nb: 11, bits: 16'h060E, data: 8'h07};
    vecs[2] = '{idx: 2, div: 4, nb: 11, bits: 16'h040E, data: 8'h07};
    vecs[3] = '{idx: 1, div: 4, nb: 11, bits: 16'h0400, data: 8'h00};
    vecs[4] = '{idx: 2, div: 4, nb: 11, bits: 16'h0600, data: 8'h00};
    vecs[5] = '{idx: 3, div: 5, nb: 11, bits: 16'h07FE, data: 8'hFF};
    vecs[6] = '{idx: 3, div: 5, nb: 11, bits: 16'h0746, data: 8'hA3};

    resetn = 1'b0;
    ivalid = '0;
    for (int i = 0; i < 4; i++) idata[i] = 8'h00;
    repeat (2) @(negedge clock);
    check("reset txd", 16'(txd), 16'h000F);
    check("reset iready", 16'(iready), 16'h000F);
    check("reset busy", 16'(busy), 16'h0000);
    resetn = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 7; v++) begin
      idata[vecs[v].idx]  = vecs[v].data;
      ivalid[vecs[v].idx] = 1'b1;
      frame(vecs[v].idx, vecs[v].div, vecs[v].nb, vecs[v].bits, 1'b0, 8'h00, 1'b0);
      idle_check(vecs[v].idx);
    end

    // Back-to-back: ivalid held high across the frame boundary.
    idata[0]  = 8'hA3;
    ivalid[0] = 1'b1;
    frame(0, 4, 10, 16'h0346, 1'b1, 8'h0F, 1'b0);
    frame(0, 4, 10, 16'h021E, 1'b0, 8'h00, 1'b0);
    idle_check(0);

    // Inputs toggle while the frame is in flight.
    idata[0]  = 8'h55;
    ivalid[0] = 1'b1;
    frame(0, 4, 10, 16'h02AA, 1'b0, 8'h00, 1'b1);
    idle_check(0);

    // Reset pulse during data bit 2 (frame bit 3, a low bit).
    idata[0]  = 8'hC3;
    ivalid[0] = 1'b1;
    check("abort ready", 16'(iready[0]), 16'd1);
    @(posedge clock);
    @(negedge clock);
    ivalid[0] = 1'b0;
    repeat (13) @(negedge clock);
    check("abort txd before", 16'(txd[0]), 16'd0);
    resetn = 1'b0;
    #1;
    check("abort txd", 16'(txd[0]), 16'd1);
    check("abort iready", 16'(iready[0]), 16'd1);
    check("abort busy", 16'(busy[0]), 16'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    idata[0]  = 8'hC3;
    ivalid[0] = 1'b1;
    frame(0, 4, 10, 16'h0386, 1'b0, 8'h00, 1'b0);
    idle_check(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
